descrambler16: RTL and testbench

- Receive-side word descrambler. It undoes the additive XOR scrambling applied to 16-bit words by the transmit-side scrambler.
- Each accepted word is XORed with a 16-bit keystream word taken from a Galois LFSR. The LFSR is reseeded at every start-of-frame, so both ends stay frame-synchronous.
- Sits between the link receive path and the word consumer. Valid/ready handshake on both sides, with one registered output stage.

---
 rtl/descrambler16.sv | 105 ++++++++++
 tb/tb_descrambler16.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/descrambler16.sv
// Receive-side additive descrambler: XORs each in-frame 16-bit word with a Galois LFSR
// keystream that is reseeded at every start-of-frame, behind a single registered output stage.
module descrambler16 #(
    parameter logic [15:0] SEED   = 16'hACE1,
    parameter logic [15:0] TAPS   = 16'hB400,
    parameter int          DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_data,
    input  logic              in_sof,
    input  logic              in_eof,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_data,
    output logic              out_sof,
    output logic              out_eof,
    output logic              in_frame,
    output logic [DROP_W-1:0] drop_cnt
);
    // Handshake: a word moves on any rising edge where valid && ready are both high on that side.
    // in_ready is high when the output register is empty or is being emptied this same cycle.
    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t            r_state, w_state_nxt;
    logic [15:0]       r_lfsr, w_lfsr_nxt, w_key;
    logic              r_out_valid, r_out_sof, r_out_eof;
    logic [15:0]       r_out_data;
    logic [DROP_W-1:0] r_drop_cnt;
    logic              w_accept, w_emit, w_drop;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : 16'h0000);
    endfunction

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_lfsr_nxt  = r_lfsr;
        w_key       = r_lfsr;
        w_emit      = 1'b0;
        w_drop      = 1'b0;
        if (w_accept) begin
            if (in_sof) begin
                // A sof always restarts the keystream, abandoning any open frame.
                w_key  = SEED;
                w_emit = 1'b1;
                if (in_eof) begin
                    w_state_nxt = ST_IDLE;
                    w_lfsr_nxt  = SEED;
                end else begin
                    w_state_nxt = ST_RUN;
                    w_lfsr_nxt  = lfsr_step(SEED);
                end
            end else if (r_state == ST_RUN) begin
                w_emit = 1'b1;
                if (in_eof) begin
                    w_state_nxt = ST_IDLE;
                    w_lfsr_nxt  = SEED;
                end else begin
                    w_lfsr_nxt  = lfsr_step(r_lfsr);
                end
            end else begin
                w_drop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_lfsr      <= SEED;
            r_out_valid <= 1'b0;
            r_out_data  <= 16'h0000;
            r_out_sof   <= 1'b0;
            r_out_eof   <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_lfsr  <= w_lfsr_nxt;
            if (in_ready) begin
                r_out_valid <= w_emit;
                if (w_emit) begin
                    r_out_data <= in_data ^ w_key;
                    r_out_sof  <= in_sof;
                    r_out_eof  <= in_eof;
                end
            end
            if (w_drop && (r_drop_cnt != {DROP_W{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + DROP_W'(1);
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sof   = r_out_sof;
    assign out_eof   = r_out_eof;
    assign in_frame  = (r_state == ST_RUN);
    assign drop_cnt  = r_drop_cnt;
endmodule

// File: tb/tb_descrambler16.sv
// Bench for descrambler16: directed vectors plus randomized frames, scored against a
// frame-level keystream model through an expected-response queue.
module tb_descrambler16;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [15:0] TAPS = 16'hB400;

    logic        clk, rst;
    logic        in_valid, in_ready, in_sof, in_eof;
    logic [15:0] in_data;
    logic        out_valid, out_ready, out_sof, out_eof, in_frame;
    logic [15:0] out_data;
    logic [7:0]  drop_cnt;

    logic        s_in_ready, s_out_valid, s_out_sof, s_out_eof, s_in_frame;
    logic [15:0] s_out_data;
    logic [1:0]  s_drop_cnt;

    logic [17:0] exp_q[$];
    logic [15:0] got_q[$];
    int n_cmp = 0;
    int n_err = 0;

    int m_k = 0;
    logic m_in_frame = 0;
    int m_drop = 0;

    descrambler16 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sof(in_sof), .in_eof(in_eof), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof), .in_frame(in_frame),
        .drop_cnt(drop_cnt)
    );

    descrambler16 #(.DROP_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .in_sof(in_sof), .in_eof(in_eof), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_data(s_out_data), .out_sof(s_out_sof), .out_eof(s_out_eof), .in_frame(s_in_frame),
        .drop_cnt(s_drop_cnt)
    );

    // clock/reset
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // keystream word k of a frame: SEED advanced k times
    function automatic logic [15:0] key_at(input int k);
        logic [15:0] s;
        s = SEED;
        for (int i = 0; i < k; i++) s = (s >> 1) ^ (s[0] ? TAPS : 16'h0000);
        return s;
    endfunction

    task automatic model_accept(input logic [15:0] d, input logic s, input logic e);
        if (s) begin
            exp_q.push_back({s, e, d ^ key_at(0)});
            m_in_frame = !e;
            m_k = e ? 0 : 1;
        end else if (m_in_frame) begin
            exp_q.push_back({s, e, d ^ key_at(m_k)});
            if (e) begin
                m_in_frame = 0;
                m_k = 0;
            end else begin
                m_k++;
            end
        end else begin
            m_drop++;
        end
    endtask

    // driver tasks: all called at a falling edge
    task automatic do_reset();
        rst = 1; in_valid = 0; out_ready = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        exp_q.delete();
        m_in_frame = 0; m_k = 0; m_drop = 0;
    endtask

    task automatic send(input logic [15:0] d, input logic s, input logic e, input logic ordy,
                        input logic rnd);
        int tries;
        logic done;
        tries = 0;
        done = 0;
        while (!done) begin
            in_valid = 1; in_data = d; in_sof = s; in_eof = e;
            out_ready = rnd ? ($urandom_range(0, 9) < 7) : ordy;
            #1;
            if (in_ready) begin
                model_accept(d, s, e);
                done = 1;
            end
            @(negedge clk);
            tries++;
            if (!done && tries > 40) begin
                check("send_timeout", 0, 1);
                done = 1;
            end
        end
        in_valid = 0;
    endtask

    task automatic idle(input int n, input logic ordy);
        in_valid = 0;
        out_ready = ordy;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int t;
        in_valid = 0;
        out_ready = 1;
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    task automatic check_got(input string name, input int idx, input logic [15:0] exp);
        if (idx < got_q.size()) check(name, got_q[idx], exp);
        else check({name, "_missing"}, 0, 1);
    endtask

    // scoreboard monitor: samples between edges, pops on every output transfer
    initial begin
        logic hold;
        logic [17:0] prev, act, exp;
        hold = 0;
        prev = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                hold = 0;
                continue;
            end
            if (hold) begin
                check("hold_valid", out_valid, 1);
                check("hold_outputs", {out_sof, out_eof, out_data}, prev);
            end
            if (out_valid && out_ready) begin
                act = {out_sof, out_eof, out_data};
                if (exp_q.size() == 0) begin
                    check("unexpected_output", act, 32'hDEAD);
                end else begin
                    exp = exp_q.pop_front();
                    check("out_word", act, exp);
                end
                got_q.push_back(out_data);
            end
            hold = out_valid && !out_ready;
            prev = {out_sof, out_eof, out_data};
        end
    end

    initial begin
        rst = 1; in_valid = 0; in_data = 0; in_sof = 0; in_eof = 0; out_ready = 0;
        @(negedge clk);
        do_reset();

        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_frame", in_frame, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_in_ready", in_ready, 1);

        // 4-word zero frame
        got_q.delete();
        send(16'h0000, 1, 0, 1, 0);
        check("frame_in_frame_w0", in_frame, 1);
        send(16'h0000, 0, 0, 1, 0);
        send(16'h0000, 0, 0, 1, 0);
        send(16'h0000, 0, 1, 1, 0);
        check("frame_in_frame_end", in_frame, 0);
        drain();
        check_got("zero_w0", 0, 16'hACE1);
        check_got("zero_w1", 1, 16'hE270);
        check_got("zero_w2", 2, 16'h7138);
        check_got("zero_w3", 3, 16'h389C);

        // single-word frame then reseeded frame
        got_q.delete();
        send(16'hFFFF, 1, 1, 1, 0);
        check("single_in_frame", in_frame, 0);
        send(16'h0000, 1, 1, 1, 0);
        drain();
        check_got("single_word", 0, 16'h531E);
        check_got("single_reseed", 1, 16'hACE1);

        // backpressure after word 1
        got_q.delete();
        send(16'h0000, 1, 0, 1, 0);
        send(16'h0000, 0, 0, 1, 0);
        in_valid = 1; in_data = 16'h0000; in_sof = 0; in_eof = 1;
        for (int i = 0; i < 3; i++) begin
            out_ready = 0;
            #1;
            check("bp_in_ready", in_ready, 0);
            check("bp_out_data", out_data, 16'hE270);
            @(negedge clk);
        end
        send(16'h0000, 0, 1, 1, 0);
        drain();
        check_got("bp_w0", 0, 16'hACE1);
        check_got("bp_w1", 1, 16'hE270);
        check_got("bp_w2", 2, 16'h7138);

        // words outside a frame are dropped
        for (int i = 0; i < 3; i++) send(16'(i + 5), 0, 0, 1, 0);
        idle(2, 1);
        check("drop3_main", drop_cnt, 3);
        check("drop3_sat", s_drop_cnt, 3);
        for (int i = 0; i < 2; i++) send(16'h1234, 0, 1, 1, 0);
        idle(2, 1);
        check("drop5_main", drop_cnt, 5);
        check("drop5_sat", s_drop_cnt, 3);

        // mid-frame sof restarts keystream
        got_q.delete();
        send(16'h0000, 1, 0, 1, 0);
        send(16'h0000, 0, 0, 1, 0);
        send(16'h0000, 1, 0, 1, 0);
        send(16'h0000, 0, 1, 1, 0);
        drain();
        check_got("midsof_w0", 2, 16'hACE1);
        check_got("midsof_w1", 3, 16'hE270);

        // reset with a word pending at the output
        send(16'h0000, 1, 0, 0, 0);
        check("pre_rst_out_valid", out_valid, 1);
        check("pre_rst_in_frame", in_frame, 1);
        do_reset();
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_in_frame", in_frame, 0);
        check("post_rst_drop_cnt", drop_cnt, 0);
        got_q.delete();
        send(16'h0000, 1, 1, 1, 0);
        drain();
        check_got("post_rst_word", 0, 16'hACE1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            send(16'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0, 1, 1);
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3), $urandom_range(0, 1));
        end
        drain();
        check("rand_drop_main", drop_cnt, (m_drop > 255) ? 255 : m_drop);
        check("rand_drop_sat", s_drop_cnt, (m_drop > 3) ? 3 : m_drop);
        check("rand_in_frame", in_frame, m_in_frame);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
